// File: rtl/acc_bank_ring.sv
// Multi-bank accumulation ring: one bank accumulates CH channel counts while
// up to NBANK-1 committed banks queue in FIFO order behind a valid/ready port.
module acc_bank_ring #(
    parameter int CH    = 4,
    parameter int IWID  = 10,
    parameter int OWID  = 16,
    parameter int NBANK = 4,
    parameter int SAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iValid,
    input  logic                     iHold,
    input  logic                     iClear,
    input  logic [CH*IWID-1:0]       iData,
    input  logic                     iSwap,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [CH*OWID-1:0]       oData,
    output logic [$clog2(NBANK)-1:0] oCount,
    output logic                     oFull,
    output logic                     oOvf
);

    localparam int PW = $clog2(NBANK);
    localparam logic [PW-1:0] LAST = PW'(NBANK - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // One extra bit catches the carry so SAT can clamp and wrap mode can drop it.
    function automatic logic [OWID-1:0] acc_add(input logic [OWID-1:0] a,
                                                 input logic [IWID-1:0] d);
        logic [OWID:0] s;
        s = {1'b0, a} + (OWID+1)'(d);
        if (SAT != 0 && s[OWID]) return '1;
        return s[OWID-1:0];
    endfunction

    logic [CH*OWID-1:0] r_bank [NBANK];
    logic [PW-1:0]      r_wr;
    logic [PW-1:0]      r_rd;
    logic [PW-1:0]      r_cnt;
    logic               r_ovf;

    logic [CH*OWID-1:0] w_acc;
    logic [CH*OWID-1:0] w_next;
    logic               w_full;
    logic               w_pop;
    logic               w_swap_req;
    logic               w_push;
    logic               w_refuse;

    assign w_acc      = r_bank[r_wr];
    assign w_full     = (r_cnt == LAST);
    assign w_pop      = oValid & iReady;
    assign w_swap_req = iSwap & ~iClear;
    assign w_push     = w_swap_req & (~w_full | w_pop);
    assign w_refuse   = w_swap_req & w_full & ~w_pop;

    always_comb begin
        w_next = w_acc;
        if (iClear) begin
            w_next = '0;
        end else if (iValid && !iHold) begin
            for (int c = 0; c < CH; c++) begin
                w_next[c*OWID +: OWID] = acc_add(w_acc[c*OWID +: OWID], iData[c*IWID +: IWID]);
            end
        end
    end

    // On commit the next bank is zeroed; when full it is the bank being popped this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANK; b++) r_bank[b] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_bank[r_wr] <= w_next;
            if (w_push) begin
                r_bank[ptr_inc(r_wr)] <= '0;
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) r_rd <= ptr_inc(r_rd);
            if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
            if (w_refuse) r_ovf <= 1'b1;
        end
    end

    assign oValid = (r_cnt != '0);
    assign oData  = oValid ? r_bank[r_rd] : '0;
    assign oCount = r_cnt;
    assign oFull  = w_full;
    assign oOvf   = r_ovf;

endmodule

// File: tb/tb_acc_bank_ring.sv
// Directed bench for acc_bank_ring: default instance plus two OWID=10 instances
// (saturating and wrapping) sharing the same stimulus.
module tb_acc_bank_ring;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iValid = 1'b0, iHold = 1'b0, iClear = 1'b0, iSwap = 1'b0, iReady = 1'b0;
    logic [39:0] iData = '0;

    logic        oValid, oFull, oOvf;
    logic [63:0] oData;
    logic [1:0]  oCount;
    logic        oValid_s, oFull_s, oOvf_s;
    logic [39:0] oData_s;
    logic [1:0]  oCount_s;
    logic        oValid_w, oFull_w, oOvf_w;
    logic [39:0] oData_w;
    logic [1:0]  oCount_w;

    int checks = 0;
    int errs = 0;

    always #5 clk = ~clk;

    acc_bank_ring #(.CH(4), .IWID(10), .OWID(16), .NBANK(4), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iHold(iHold), .iClear(iClear),
        .iData(iData), .iSwap(iSwap), .oValid(oValid), .iReady(iReady), .oData(oData),
        .oCount(oCount), .oFull(oFull), .oOvf(oOvf));

    acc_bank_ring #(.CH(4), .IWID(10), .OWID(10), .NBANK(4), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iHold(iHold), .iClear(iClear),
        .iData(iData), .iSwap(iSwap), .oValid(oValid_s), .iReady(iReady), .oData(oData_s),
        .oCount(oCount_s), .oFull(oFull_s), .oOvf(oOvf_s));

    acc_bank_ring #(.CH(4), .IWID(10), .OWID(10), .NBANK(4), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .iHold(iHold), .iClear(iClear),
        .iData(iData), .iSwap(iSwap), .oValid(oValid_w), .iReady(iReady), .oData(oData_w),
        .oCount(oCount_w), .oFull(oFull_w), .oOvf(oOvf_w));

    function automatic logic [39:0] pk10(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [63:0] pk16(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        iValid = 0; iHold = 0; iClear = 0; iSwap = 0; iReady = 0; iData = '0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (oValid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", oValid); end
        checks++; if (oData !== 64'd0) begin errs++; $display("FAIL reset_data got %h want 0", oData); end
        checks++; if (oCount !== 2'd0) begin errs++; $display("FAIL reset_count got %0d want 0", oCount); end
        checks++; if (oFull !== 1'b0 || oOvf !== 1'b0) begin errs++; $display("FAIL reset_flags got full=%b ovf=%b want 0 0", oFull, oOvf); end
    endtask

    task automatic test_basic();
        do_reset();
        iValid = 1; iData = pk10(1, 2, 3, 4);
        repeat (4) tick();
        checks++; if (oValid !== 1'b0) begin errs++; $display("FAIL basic_prevalid got %b want 0", oValid); end
        iSwap = 1;
        tick();
        checks++; if (oValid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b want 1", oValid); end
        checks++; if (oData !== pk16(5, 10, 15, 20)) begin errs++; $display("FAIL basic_data got %h want %h", oData, pk16(5, 10, 15, 20)); end
        checks++; if (oCount !== 2'd1) begin errs++; $display("FAIL basic_count got %0d want 1", oCount); end
        iValid = 0; iSwap = 0; iReady = 1;
        tick();
        checks++; if (oValid !== 1'b0 || oData !== 64'd0 || oCount !== 2'd0) begin
            errs++; $display("FAIL basic_pop got v=%b d=%h c=%0d want 0 0 0", oValid, oData, oCount); end
        iReady = 0; iValid = 1; iHold = 1; iData = pk10(9, 9, 9, 9);
        tick();
        iHold = 0; iValid = 0; iSwap = 1;
        tick();
        iSwap = 0;
        checks++; if (oValid !== 1'b1 || oData !== 64'd0) begin
            errs++; $display("FAIL basic_hold got v=%b d=%h want 1 0", oValid, oData); end
    endtask

    task automatic test_saturate();
        do_reset();
        iValid = 1; iData = pk10(1023, 1023, 1023, 1023);
        tick();
        tick();
        iSwap = 1;
        tick();
        iSwap = 0; iValid = 0;
        checks++; if (oData_s !== pk10(1023, 1023, 1023, 1023)) begin errs++; $display("FAIL sat_clamp got %h want %h", oData_s, pk10(1023, 1023, 1023, 1023)); end
        checks++; if (oData_w !== pk10(1021, 1021, 1021, 1021)) begin errs++; $display("FAIL sat_wrap got %h want %h", oData_w, pk10(1021, 1021, 1021, 1021)); end
        checks++; if (oData !== pk16(3069, 3069, 3069, 3069)) begin errs++; $display("FAIL sat_wide got %h want %h", oData, pk16(3069, 3069, 3069, 3069)); end
    endtask

    task automatic test_full_ovf();
        do_reset();
        iValid = 1; iSwap = 1;
        iData = pk10(1, 1, 1, 1); tick();
        iData = pk10(2, 2, 2, 2); tick();
        iData = pk10(3, 3, 3, 3); tick();
        checks++; if (oFull !== 1'b1 || oCount !== 2'd3 || oOvf !== 1'b0) begin
            errs++; $display("FAIL full_state got full=%b cnt=%0d ovf=%b want 1 3 0", oFull, oCount, oOvf); end
        checks++; if (oData !== pk16(1, 1, 1, 1)) begin errs++; $display("FAIL full_head got %h want %h", oData, pk16(1, 1, 1, 1)); end
        iData = pk10(4, 4, 4, 4); tick();
        checks++; if (oOvf !== 1'b1 || oCount !== 2'd3) begin
            errs++; $display("FAIL ovf_refuse got ovf=%b cnt=%0d want 1 3", oOvf, oCount); end
        checks++; if (oData !== pk16(1, 1, 1, 1)) begin errs++; $display("FAIL ovf_stable got %h want %h", oData, pk16(1, 1, 1, 1)); end
        iSwap = 0; iData = pk10(5, 5, 5, 5); tick();
        iValid = 0; iSwap = 1; iReady = 1; tick();
        iSwap = 0;
        checks++; if (oCount !== 2'd3 || oData !== pk16(2, 2, 2, 2)) begin
            errs++; $display("FAIL ovf_pushpop got cnt=%0d d=%h want 3 %h", oCount, oData, pk16(2, 2, 2, 2)); end
        tick();
        checks++; if (oData !== pk16(3, 3, 3, 3)) begin errs++; $display("FAIL ovf_order2 got %h want %h", oData, pk16(3, 3, 3, 3)); end
        tick();
        checks++; if (oData !== pk16(9, 9, 9, 9)) begin errs++; $display("FAIL ovf_grown got %h want %h", oData, pk16(9, 9, 9, 9)); end
        checks++; if (oOvf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", oOvf); end
        tick();
        checks++; if (oValid !== 1'b0 || oCount !== 2'd0) begin
            errs++; $display("FAIL ovf_drain got v=%b cnt=%0d want 0 0", oValid, oCount); end
        iReady = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        iValid = 1; iSwap = 1;
        iData = pk10(1, 1, 1, 1); tick();
        iData = pk10(2, 2, 2, 2); tick();
        iData = pk10(3, 3, 3, 3); tick();
        iData = pk10(4, 4, 4, 4); iReady = 1; tick();
        checks++; if (oOvf !== 1'b0 || oCount !== 2'd3) begin
            errs++; $display("FAIL b2b_accept got ovf=%b cnt=%0d want 0 3", oOvf, oCount); end
        checks++; if (oData !== pk16(2, 2, 2, 2)) begin errs++; $display("FAIL b2b_head got %h want %h", oData, pk16(2, 2, 2, 2)); end
        iSwap = 0; iValid = 0;
        tick();
        checks++; if (oData !== pk16(3, 3, 3, 3)) begin errs++; $display("FAIL b2b_order3 got %h want %h", oData, pk16(3, 3, 3, 3)); end
        tick();
        checks++; if (oData !== pk16(4, 4, 4, 4)) begin errs++; $display("FAIL b2b_order4 got %h want %h", oData, pk16(4, 4, 4, 4)); end
        tick();
        iReady = 0; iSwap = 1;
        tick();
        iSwap = 0;
        checks++; if (oValid !== 1'b1 || oData !== 64'd0) begin
            errs++; $display("FAIL b2b_reuse got v=%b d=%h want 1 0", oValid, oData); end
    endtask

    task automatic test_clear_swap();
        do_reset();
        iValid = 1; iData = pk10(7, 7, 7, 7); tick();
        iValid = 0; iClear = 1; iSwap = 1; tick();
        checks++; if (oCount !== 2'd0 || oValid !== 1'b0 || oOvf !== 1'b0) begin
            errs++; $display("FAIL clr_noswap got cnt=%0d v=%b ovf=%b want 0 0 0", oCount, oValid, oOvf); end
        iClear = 0; tick();
        iSwap = 0;
        checks++; if (oValid !== 1'b1 || oData !== 64'd0) begin
            errs++; $display("FAIL clr_zero got v=%b d=%h want 1 0", oValid, oData); end
    endtask

    task automatic test_async_reset();
        do_reset();
        iValid = 1; iSwap = 1;
        iData = pk10(1, 1, 1, 1); tick();
        iData = pk10(2, 2, 2, 2); tick();
        iData = pk10(3, 3, 3, 3); tick();
        iData = pk10(4, 4, 4, 4); tick();
        iValid = 0; iSwap = 0; iReady = 1; tick();
        checks++; if (oCount !== 2'd2 || oOvf !== 1'b1) begin
            errs++; $display("FAIL arst_pre got cnt=%0d ovf=%b want 2 1", oCount, oOvf); end
        iReady = 0; iValid = 1; iData = pk10(5, 5, 5, 5); tick();
        #2 rst_n = 0;
        #1;
        checks++; if (oValid !== 1'b0 || oData !== 64'd0 || oOvf !== 1'b0 || oCount !== 2'd0) begin
            errs++; $display("FAIL arst_now got v=%b d=%h ovf=%b cnt=%0d want 0 0 0 0", oValid, oData, oOvf, oCount); end
        iValid = 0; iData = '0;
        rst_n = 1;
        tick();
        iSwap = 1; tick();
        iSwap = 0;
        checks++; if (oValid !== 1'b1 || oData !== 64'd0 || oCount !== 2'd1) begin
            errs++; $display("FAIL arst_clean got v=%b d=%h cnt=%0d want 1 0 1", oValid, oData, oCount); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_full_ovf();
        test_back_to_back();
        test_clear_swap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
